// File: rtl/csr_file_pkg.sv
// csr_file_pkg
//   Shared CSR definitions for csr_file and its counter sub-module:
//   bus width constants, 12-bit CSR addresses, mstatus bit positions,
//   per-register writable masks, and helpers that decide whether an address
//   is software-writable and what a write to it actually stores.
package csr_file_pkg;

  localparam int          RegBus   = 32;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // MPP is hard-wired to machine mode (11); it always reads back as set.
  localparam logic [31:0] MSTATUS_MPP_FIXED = 32'h0000_1800;
  localparam logic [31:0] MSTATUS_WMASK     = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK         = 32'h0000_0888;
  localparam logic [31:0] ALIGN4_MASK       = 32'hFFFF_FFFC;

  function automatic logic csr_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
        csr_writable = 1'b1;
      default: csr_writable = 1'b0;
    endcase
  endfunction

  // Value a write to addr would leave in the register; also the bypass value.
  function automatic logic [31:0] csr_wmask_data(input logic [11:0] addr,
                                                 input logic [31:0] data);
    case (addr)
      CSR_MSTATUS:          csr_wmask_data = (data & MSTATUS_WMASK) | MSTATUS_MPP_FIXED;
      CSR_MIE:              csr_wmask_data = data & MIE_WMASK;
      CSR_MTVEC, CSR_MEPC:  csr_wmask_data = data & ALIGN4_MASK;
      default:              csr_wmask_data = data;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// csr_counter64
//   64-bit free-running/event counter with independently writable halves.
//   A write to either half takes priority over the increment for the whole
//   counter in that cycle, so the unwritten half holds and no carry occurs.
// Ports
//   clk_i     in   1   clock
//   n_rst_i   in   1   synchronous reset, active-low
//   inc_i     in   1   increment by one this cycle
//   we_lo_i   in   1   load bits [31:0] from wdata_i
//   we_hi_i   in   1   load bits [63:32] from wdata_i
//   wdata_i   in   32  write data
//   cnt_o     out  64  current count
module csr_counter64
  import csr_file_pkg::*;
(
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              inc_i,
  input  logic              we_lo_i,
  input  logic              we_hi_i,
  input  logic [RegBus-1:0] wdata_i,
  output logic [63:0]       cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (we_lo_i || we_hi_i) begin
      if (we_lo_i) cnt_d[31:0]  = wdata_i;
      if (we_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) cnt_q <= 64'd0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// csr_file
//   Machine-mode CSR storage at the write-back end of the pipeline. Commits
//   CSR writes from MEM/WB, counts mcycle/minstret, applies trap/mret state
//   changes, and serves a combinational read port to EX that forwards a
//   same-cycle write. Trap/mret updates are not forwarded: EX is flushed on a
//   trap, and an mret in flight never coincides with a dependent CSR read.
// Ports
//   clk_i, n_rst_i                        clock, synchronous active-low reset
//   csr_we_i/csr_waddr_i/csr_wdata_i      CSR write from MEM/WB
//   instret_incr_i                        retire strobe (+1 minstret)
//   csr_raddr_i/csr_rdata_o               combinational read port for EX
//   trap_i, trap_cause_i/epc_i/tval_i     trap entry from ctrl
//   mret_i                                mret retiring
//   mtvec_o, mepc_o, mstatus_mie_o, mie_o state exported to the trap unit
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              csr_we_i,
  input  logic [RegBus-1:0] csr_waddr_i,
  input  logic [RegBus-1:0] csr_wdata_i,
  input  logic              instret_incr_i,
  input  logic [RegBus-1:0] csr_raddr_i,
  output logic [RegBus-1:0] csr_rdata_o,
  input  logic              trap_i,
  input  logic [RegBus-1:0] trap_cause_i,
  input  logic [RegBus-1:0] trap_epc_i,
  input  logic [RegBus-1:0] trap_tval_i,
  input  logic              mret_i,
  output logic [RegBus-1:0] mtvec_o,
  output logic [RegBus-1:0] mepc_o,
  output logic              mstatus_mie_o,
  output logic [RegBus-1:0] mie_o
);

  logic [11:0] waddr, raddr;
  logic [31:0] wdata_m;
  logic        unused_addr_bits;

  assign waddr   = csr_waddr_i[11:0];
  assign raddr   = csr_raddr_i[11:0];
  assign wdata_m = csr_wmask_data(waddr, csr_wdata_i);
  assign unused_addr_bits = ^{csr_waddr_i[31:12], csr_raddr_i[31:12]};

  logic we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause, we_mtval;
  logic we_mcycle, we_mcycleh, we_minstret, we_minstreth;

  assign we_mstatus   = csr_we_i && (waddr == CSR_MSTATUS);
  assign we_mie       = csr_we_i && (waddr == CSR_MIE);
  assign we_mtvec     = csr_we_i && (waddr == CSR_MTVEC);
  assign we_mscratch  = csr_we_i && (waddr == CSR_MSCRATCH);
  assign we_mepc      = csr_we_i && (waddr == CSR_MEPC);
  assign we_mcause    = csr_we_i && (waddr == CSR_MCAUSE);
  assign we_mtval     = csr_we_i && (waddr == CSR_MTVAL);
  assign we_mcycle    = csr_we_i && (waddr == CSR_MCYCLE);
  assign we_mcycleh   = csr_we_i && (waddr == CSR_MCYCLEH);
  assign we_minstret  = csr_we_i && (waddr == CSR_MINSTRET);
  assign we_minstreth = csr_we_i && (waddr == CSR_MINSTRETH);

  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q,      mie_d;
  logic [31:0] mtvec_q,    mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q,     mepc_d;
  logic [31:0] mcause_q,   mcause_d;
  logic [31:0] mtval_q,    mtval_d;

  // Per-register priority: trap > mret > software write. Registers that
  // trap/mret do not touch still take a same-cycle write.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;

    if (trap_i) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (we_mstatus) begin
      mstatus_mie_d  = wdata_m[MSTATUS_MIE_BIT];
      mstatus_mpie_d = wdata_m[MSTATUS_MPIE_BIT];
    end

    if (trap_i) begin
      mepc_d   = trap_epc_i & ALIGN4_MASK;
      mcause_d = trap_cause_i;
      mtval_d  = trap_tval_i;
    end else begin
      if (we_mepc)   mepc_d   = wdata_m;
      if (we_mcause) mcause_d = wdata_m;
      if (we_mtval)  mtval_d  = wdata_m;
    end

    if (we_mie)      mie_d      = wdata_m;
    if (we_mtvec)    mtvec_d    = wdata_m;
    if (we_mscratch) mscratch_d = wdata_m;
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= ZeroWord;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= ZeroWord;
      mepc_q         <= ZeroWord;
      mcause_q       <= ZeroWord;
      mtval_q        <= ZeroWord;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

  logic [63:0] mcycle, minstret;

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .inc_i   (1'b1),
    .we_lo_i (we_mcycle),
    .we_hi_i (we_mcycleh),
    .wdata_i (csr_wdata_i),
    .cnt_o   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .inc_i   (instret_incr_i),
    .we_lo_i (we_minstret),
    .we_hi_i (we_minstreth),
    .wdata_i (csr_wdata_i),
    .cnt_o   (minstret)
  );

  logic [31:0] mstatus_rd;
  assign mstatus_rd = MSTATUS_MPP_FIXED
                    | ({31'd0, mstatus_mpie_q} << MSTATUS_MPIE_BIT)
                    | ({31'd0, mstatus_mie_q}  << MSTATUS_MIE_BIT);

  always_comb begin
    csr_rdata_o = ZeroWord;
    if (csr_we_i && (waddr == raddr) && csr_writable(waddr)) begin
      csr_rdata_o = wdata_m;
    end else begin
      case (raddr)
        CSR_MSTATUS:                 csr_rdata_o = mstatus_rd;
        CSR_MISA:                    csr_rdata_o = MISA_VALUE;
        CSR_MIE:                     csr_rdata_o = mie_q;
        CSR_MTVEC:                   csr_rdata_o = mtvec_q;
        CSR_MSCRATCH:                csr_rdata_o = mscratch_q;
        CSR_MEPC:                    csr_rdata_o = mepc_q;
        CSR_MCAUSE:                  csr_rdata_o = mcause_q;
        CSR_MTVAL:                   csr_rdata_o = mtval_q;
        CSR_MIP:                     csr_rdata_o = ZeroWord;
        CSR_MCYCLE,   CSR_CYCLE:     csr_rdata_o = mcycle[31:0];
        CSR_MCYCLEH,  CSR_CYCLEH:    csr_rdata_o = mcycle[63:32];
        CSR_MINSTRET, CSR_INSTRET:   csr_rdata_o = minstret[31:0];
        CSR_MINSTRETH, CSR_INSTRETH: csr_rdata_o = minstret[63:32];
        CSR_MHARTID:                 csr_rdata_o = MHARTID;
        default:                     csr_rdata_o = ZeroWord;
      endcase
    end
  end

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mstatus_mie_o = mstatus_mie_q;
  assign mie_o         = mie_q;

endmodule

// File: tb/tb_csr_file.sv
`timescale 1ns/1ps
module tb_csr_file;

  localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0200;
  localparam logic [31:0] TB_MHARTID     = 32'h0000_0005;
  localparam logic [31:0] TB_MISA        = 32'h4000_0100;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        csr_we_i;
  logic [31:0] csr_waddr_i, csr_wdata_i;
  logic        instret_incr_i;
  logic [31:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        trap_i;
  logic [31:0] trap_cause_i, trap_epc_i, trap_tval_i;
  logic        mret_i;
  logic [31:0] mtvec_o, mepc_o, mie_o;
  logic        mstatus_mie_o;

  int total = 0;
  int bad   = 0;

  csr_file #(
    .MISA_VALUE  (TB_MISA),
    .MTVEC_RESET (TB_MTVEC_RESET),
    .MHARTID     (TB_MHARTID)
  ) dut (
    .clk_i          (clk_i),
    .n_rst_i        (n_rst_i),
    .csr_we_i       (csr_we_i),
    .csr_waddr_i    (csr_waddr_i),
    .csr_wdata_i    (csr_wdata_i),
    .instret_incr_i (instret_incr_i),
    .csr_raddr_i    (csr_raddr_i),
    .csr_rdata_o    (csr_rdata_o),
    .trap_i         (trap_i),
    .trap_cause_i   (trap_cause_i),
    .trap_epc_i     (trap_epc_i),
    .trap_tval_i    (trap_tval_i),
    .mret_i         (mret_i),
    .mtvec_o        (mtvec_o),
    .mepc_o         (mepc_o),
    .mstatus_mie_o  (mstatus_mie_o),
    .mie_o          (mie_o)
  );

  always #50 clk_i = ~clk_i;

  // Advance past one rising edge; inputs are then driven well away from it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Upper address bits are junk on purpose: only [11:0] may be decoded.
  task automatic rd(input logic [11:0] a);
    csr_raddr_i = {20'hABCDE, a};
    #1;
  endtask

  task automatic set_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we_i    = 1'b1;
    csr_waddr_i = {20'h13579, a};
    csr_wdata_i = d;
  endtask

  task automatic idle_inputs();
    csr_we_i = 1'b0; csr_waddr_i = 32'h0; csr_wdata_i = 32'h0;
    instret_incr_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
    trap_cause_i = 32'h0; trap_epc_i = 32'h0; trap_tval_i = 32'h0;
  endtask

  task automatic test_reset();
    n_rst_i = 1'b0;
    idle_inputs();
    csr_raddr_i = 32'h0;
    repeat (3) step();
    n_rst_i = 1'b1;
    rd(12'h300); total++;
    if (csr_rdata_o !== 32'h0000_1800) begin bad++; $display("FAIL reset_mstatus got=%h exp=%h", csr_rdata_o, 32'h0000_1800); end
    rd(12'h305); total++;
    if (csr_rdata_o !== TB_MTVEC_RESET) begin bad++; $display("FAIL reset_mtvec got=%h exp=%h", csr_rdata_o, TB_MTVEC_RESET); end
    total++;
    if (mtvec_o !== TB_MTVEC_RESET || mepc_o !== 32'h0 || mie_o !== 32'h0 || mstatus_mie_o !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got mtvec=%h mepc=%h mie=%h mstie=%b", mtvec_o, mepc_o, mie_o, mstatus_mie_o);
    end
    rd(12'hB00); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_mcycle got=%h exp=0", csr_rdata_o); end
    rd(12'h301); total++;
    if (csr_rdata_o !== TB_MISA) begin bad++; $display("FAIL misa got=%h exp=%h", csr_rdata_o, TB_MISA); end
    rd(12'hF14); total++;
    if (csr_rdata_o !== TB_MHARTID) begin bad++; $display("FAIL mhartid got=%h exp=%h", csr_rdata_o, TB_MHARTID); end
    rd(12'h344); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL mip got=%h exp=0", csr_rdata_o); end
    repeat (10) step();
    rd(12'hB00); total++;
    if (csr_rdata_o !== 32'd10) begin bad++; $display("FAIL mcycle_10 got=%h exp=%h", csr_rdata_o, 32'd10); end
    rd(12'hC00); total++;
    if (csr_rdata_o !== 32'd10) begin bad++; $display("FAIL cycle_alias got=%h exp=%h", csr_rdata_o, 32'd10); end
  endtask

  task automatic test_write_bypass();
    set_wr(12'h305, 32'h8000_0007);
    rd(12'h305); total++;
    if (csr_rdata_o !== 32'h8000_0004) begin bad++; $display("FAIL mtvec_bypass got=%h exp=%h", csr_rdata_o, 32'h8000_0004); end
    total++;
    if (mtvec_o !== TB_MTVEC_RESET) begin bad++; $display("FAIL mtvec_early got=%h exp=%h", mtvec_o, TB_MTVEC_RESET); end
    step();
    csr_we_i = 1'b0;
    rd(12'h305); total++;
    if (csr_rdata_o !== 32'h8000_0004 || mtvec_o !== 32'h8000_0004) begin
      bad++; $display("FAIL mtvec_commit got rd=%h out=%h exp=%h", csr_rdata_o, mtvec_o, 32'h8000_0004);
    end
    set_wr(12'h304, 32'hFFFF_FFFF);
    step();
    csr_we_i = 1'b0;
    rd(12'h304); total++;
    if (csr_rdata_o !== 32'h0000_0888 || mie_o !== 32'h0000_0888) begin
      bad++; $display("FAIL mie_mask got rd=%h out=%h exp=%h", csr_rdata_o, mie_o, 32'h0000_0888);
    end
    set_wr(12'h300, 32'hFFFF_FFFF);
    rd(12'h300); total++;
    if (csr_rdata_o !== 32'h0000_1888) begin bad++; $display("FAIL mstatus_bypass got=%h exp=%h", csr_rdata_o, 32'h0000_1888); end
    step();
    set_wr(12'h300, 32'h0);
    step();
    set_wr(12'h301, 32'h0);
    rd(12'h301); total++;
    if (csr_rdata_o !== TB_MISA) begin bad++; $display("FAIL misa_ro_bypass got=%h exp=%h", csr_rdata_o, TB_MISA); end
    step();
    set_wr(12'h7C0, 32'h1234_5678);
    step();
    csr_we_i = 1'b0;
    rd(12'h301); total++;
    if (csr_rdata_o !== TB_MISA) begin bad++; $display("FAIL misa_ro got=%h exp=%h", csr_rdata_o, TB_MISA); end
    rd(12'h7C0); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=0", csr_rdata_o); end
    rd(12'h300); total++;
    if (csr_rdata_o !== 32'h0000_1800) begin bad++; $display("FAIL mstatus_clear got=%h exp=%h", csr_rdata_o, 32'h0000_1800); end
  endtask

  task automatic test_counter_carry();
    set_wr(12'hB00, 32'hFFFF_FFFE);
    step();
    set_wr(12'hB80, 32'h0);
    step();
    csr_we_i = 1'b0;
    rd(12'hB00); total++;
    if (csr_rdata_o !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mcycle_hold got=%h exp=%h", csr_rdata_o, 32'hFFFF_FFFE); end
    rd(12'hB80); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL mcycleh_wr got=%h exp=0", csr_rdata_o); end
    step(); step();
    rd(12'hB00); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL mcycle_wrap_lo got=%h exp=0", csr_rdata_o); end
    rd(12'hB80); total++;
    if (csr_rdata_o !== 32'h1) begin bad++; $display("FAIL mcycle_carry got=%h exp=1", csr_rdata_o); end
    step();
    rd(12'hB00); total++;
    if (csr_rdata_o !== 32'h1) begin bad++; $display("FAIL mcycle_lo_3 got=%h exp=1", csr_rdata_o); end
    rd(12'hC80); total++;
    if (csr_rdata_o !== 32'h1) begin bad++; $display("FAIL cycleh_alias got=%h exp=1", csr_rdata_o); end
  endtask

  task automatic test_minstret();
    rd(12'hB02); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL minstret_idle got=%h exp=0", csr_rdata_o); end
    for (int i = 0; i < 5; i++) begin
      instret_incr_i = 1'b1;
      step();
      instret_incr_i = 1'b0;
      step();
    end
    rd(12'hB02); total++;
    if (csr_rdata_o !== 32'd5) begin bad++; $display("FAIL minstret_5 got=%h exp=5", csr_rdata_o); end
    instret_incr_i = 1'b1;
    set_wr(12'hB02, 32'h0);
    step();
    instret_incr_i = 1'b0; csr_we_i = 1'b0;
    rd(12'hB02); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL minstret_wr_wins got=%h exp=0", csr_rdata_o); end
    instret_incr_i = 1'b1;
    step();
    instret_incr_i = 1'b0;
    rd(12'hC02); total++;
    if (csr_rdata_o !== 32'h1) begin bad++; $display("FAIL minstret_after got=%h exp=1", csr_rdata_o); end
    set_wr(12'hB02, 32'hFFFF_FFFF);
    step();
    set_wr(12'hB82, 32'hFFFF_FFFF);
    step();
    csr_we_i = 1'b0;
    rd(12'hC82); total++;
    if (csr_rdata_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL minstreth_wr got=%h exp=%h", csr_rdata_o, 32'hFFFF_FFFF); end
    instret_incr_i = 1'b1;
    step();
    instret_incr_i = 1'b0;
    rd(12'hB02); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL minstret_wrap_lo got=%h exp=0", csr_rdata_o); end
    rd(12'hB82); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL minstret_wrap_hi got=%h exp=0", csr_rdata_o); end
  endtask

  task automatic test_trap_mret();
    set_wr(12'h300, 32'h0000_0008);
    step();
    csr_we_i = 1'b0;
    rd(12'h300); total++;
    if (csr_rdata_o !== 32'h0000_1808 || mstatus_mie_o !== 1'b1) begin
      bad++; $display("FAIL mstatus_mie_set got=%h mie=%b exp=%h", csr_rdata_o, mstatus_mie_o, 32'h0000_1808);
    end
    trap_i = 1'b1; trap_epc_i = 32'h0000_0103; trap_cause_i = 32'h8000_000B; trap_tval_i = 32'h0000_DEAD;
    step();
    trap_i = 1'b0;
    rd(12'h341); total++;
    if (csr_rdata_o !== 32'h0000_0100 || mepc_o !== 32'h0000_0100) begin
      bad++; $display("FAIL trap_mepc got rd=%h out=%h exp=%h", csr_rdata_o, mepc_o, 32'h0000_0100);
    end
    rd(12'h342); total++;
    if (csr_rdata_o !== 32'h8000_000B) begin bad++; $display("FAIL trap_mcause got=%h exp=%h", csr_rdata_o, 32'h8000_000B); end
    rd(12'h343); total++;
    if (csr_rdata_o !== 32'h0000_DEAD) begin bad++; $display("FAIL trap_mtval got=%h exp=%h", csr_rdata_o, 32'h0000_DEAD); end
    rd(12'h300); total++;
    if (csr_rdata_o !== 32'h0000_1880 || mstatus_mie_o !== 1'b0) begin
      bad++; $display("FAIL trap_mstatus got=%h exp=%h", csr_rdata_o, 32'h0000_1880);
    end
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    rd(12'h300); total++;
    if (csr_rdata_o !== 32'h0000_1888 || mstatus_mie_o !== 1'b1) begin
      bad++; $display("FAIL mret_mstatus got=%h exp=%h", csr_rdata_o, 32'h0000_1888);
    end
    trap_i = 1'b1; mret_i = 1'b1; trap_epc_i = 32'h0000_0040;
    step();
    trap_i = 1'b0; mret_i = 1'b0;
    rd(12'h300); total++;
    if (csr_rdata_o !== 32'h0000_1880) begin bad++; $display("FAIL trap_over_mret got=%h exp=%h", csr_rdata_o, 32'h0000_1880); end
    mret_i = 1'b1;
    set_wr(12'h300, 32'h0);
    step();
    mret_i = 1'b0; csr_we_i = 1'b0;
    rd(12'h300); total++;
    if (csr_rdata_o !== 32'h0000_1888) begin bad++; $display("FAIL mret_over_write got=%h exp=%h", csr_rdata_o, 32'h0000_1888); end
  endtask

  task automatic test_trap_write();
    trap_i = 1'b1; trap_epc_i = 32'h0000_0200; trap_cause_i = 32'h0000_0002; trap_tval_i = 32'h0;
    set_wr(12'h341, 32'h0000_0055);
    rd(12'h341); total++;
    if (csr_rdata_o !== 32'h0000_0054) begin bad++; $display("FAIL trap_we_bypass got=%h exp=%h", csr_rdata_o, 32'h0000_0054); end
    step();
    set_wr(12'h340, 32'h0000_00AA);
    trap_epc_i = 32'h0000_0300;
    step();
    trap_i = 1'b0; csr_we_i = 1'b0;
    rd(12'h340); total++;
    if (csr_rdata_o !== 32'h0000_00AA) begin bad++; $display("FAIL trap_mscratch got=%h exp=%h", csr_rdata_o, 32'h0000_00AA); end
    rd(12'h341); total++;
    if (csr_rdata_o !== 32'h0000_0300) begin bad++; $display("FAIL trap_beats_we got=%h exp=%h", csr_rdata_o, 32'h0000_0300); end
    set_wr(12'h342, 32'h0000_1234);
    step();
    csr_we_i = 1'b0;
    rd(12'h342); total++;
    if (csr_rdata_o !== 32'h0000_1234) begin bad++; $display("FAIL mcause_wr got=%h exp=%h", csr_rdata_o, 32'h0000_1234); end
    // Reset dominates a simultaneous trap and write.
    trap_i = 1'b1; trap_epc_i = 32'h0000_0444; trap_cause_i = 32'h1; trap_tval_i = 32'h9;
    set_wr(12'h305, 32'h0000_0FF0);
    instret_incr_i = 1'b1;
    n_rst_i = 1'b0;
    step();
    idle_inputs();
    n_rst_i = 1'b1;
    rd(12'h300); total++;
    if (csr_rdata_o !== 32'h0000_1800) begin bad++; $display("FAIL rst_mstatus got=%h exp=%h", csr_rdata_o, 32'h0000_1800); end
    rd(12'h340); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_mscratch got=%h exp=0", csr_rdata_o); end
    rd(12'h342); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_mcause got=%h exp=0", csr_rdata_o); end
    rd(12'h343); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_mtval got=%h exp=0", csr_rdata_o); end
    total++;
    if (mtvec_o !== TB_MTVEC_RESET || mepc_o !== 32'h0 || mie_o !== 32'h0 || mstatus_mie_o !== 1'b0) begin
      bad++; $display("FAIL rst_outputs got mtvec=%h mepc=%h mie=%h mstie=%b", mtvec_o, mepc_o, mie_o, mstatus_mie_o);
    end
    rd(12'hB00); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_mcycle got=%h exp=0", csr_rdata_o); end
    rd(12'hB02); total++;
    if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_minstret got=%h exp=0", csr_rdata_o); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_counter_carry();
    test_minstret();
    test_trap_mret();
    test_trap_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
